fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage. It issues word-aligned requests to instruction
// memory under a credit limit, tracks in-order responses, buffers the
// returned instructions for decode, and squashes stale traffic on a redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  // Control state
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [CW-1:0] pcq_cnt_q, pcq_cnt_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  // Data storage (no reset; validity is tracked by the counters above)
  logic [31:0] pcq_mem_q    [MAX_OUT];
  logic [31:0] fifo_pc_q    [MAX_OUT];
  logic [31:0] fifo_instr_q [MAX_OUT];

  logic [CW+1:0] in_flight;
  logic          credit_ok;
  logic          req_fire;
  logic          resp_keep;
  logic          resp_drop;
  logic          id_fire;
  logic [CW-1:0] redir_drop_sum;
  logic          unused_redir_lsb;

  // Circular pointer advance that wraps at MAX_OUT entries
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUT - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Low redirect bits are forced to zero, so they are intentionally ignored
  assign unused_redir_lsb = ^redirect_pc[1:0];

  // Dropped-pending responses still occupy memory-side slots, so they count as credit
  assign in_flight = (CW+2)'(pcq_cnt_q) + (CW+2)'(drop_q) + (CW+2)'(fifo_cnt_q);
  assign credit_ok = in_flight < (CW+2)'(MAX_OUT);

  assign imem_req  = !rst && !redirect_valid && credit_ok;
  assign imem_addr = fetch_pc_q;
  assign id_valid  = !rst && !redirect_valid && (fifo_cnt_q != '0);
  assign id_instr  = fifo_instr_q[fifo_rd_q];
  assign id_pc     = fifo_pc_q[fifo_rd_q];

  assign req_fire  = imem_req && imem_ready;
  assign resp_keep = imem_rvalid && (drop_q == '0) && !redirect_valid;
  assign resp_drop = imem_rvalid && (drop_q != '0) && !redirect_valid;
  assign id_fire   = id_valid && id_ready;

  // A response in the redirect cycle is itself squashed, so it is not added to the drop count
  assign redir_drop_sum = drop_q + pcq_cnt_q;

  // Next-state for fetch PC, PC queue, drop counter and instruction FIFO
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pcq_wr_d   = pcq_wr_q;
    pcq_rd_d   = pcq_rd_q;
    pcq_cnt_d  = pcq_cnt_q;
    drop_d     = drop_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      pcq_wr_d   = '0;
      pcq_rd_d   = '0;
      pcq_cnt_d  = '0;
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
      if (imem_rvalid && (redir_drop_sum != '0)) drop_d = redir_drop_sum - CW'(1);
      else                                       drop_d = redir_drop_sum;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        pcq_wr_d   = ptr_inc(pcq_wr_q);
      end
      if (resp_keep) begin
        pcq_rd_d  = ptr_inc(pcq_rd_q);
        fifo_wr_d = ptr_inc(fifo_wr_q);
      end
      if (resp_drop) drop_d = drop_q - CW'(1);
      if (id_fire) fifo_rd_d = ptr_inc(fifo_rd_q);
      pcq_cnt_d  = pcq_cnt_q + CW'(req_fire) - CW'(resp_keep);
      fifo_cnt_d = fifo_cnt_q + CW'(resp_keep) - CW'(id_fire);
    end
  end

  // Control registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
      pcq_cnt_q  <= '0;
      drop_q     <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
      pcq_cnt_q  <= pcq_cnt_d;
      drop_q     <= drop_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Storage writes: record issued PCs and capture kept responses with their PC
  always_ff @(posedge clk) begin
    if (req_fire) pcq_mem_q[pcq_wr_q] <= fetch_pc_q;
    if (resp_keep) begin
      fifo_pc_q[fifo_wr_q]    <= pcq_mem_q[pcq_rd_q];
      fifo_instr_q[fifo_wr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small in-order instruction memory
// whose returned word is the address XOR a fixed key.
module tb_fetch_stage;

  localparam logic [31:0] MKEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int n_cmp = 0;
  int n_bad = 0;
  int ccount;
  logic mem_en;

  logic [31:0] mq[$];
  logic [31:0] req_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  int          got_cyc[$];

  fetch_stage #(.RESET_PC(32'h0000_0000), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock cycle: sample outputs, advance the edge, update the memory model
  task automatic cyc();
    logic fired, consumed;
    logic [31:0] a;
    #1;
    fired    = imem_req && imem_ready;
    a        = imem_addr;
    consumed = imem_rvalid;
    if (id_valid && id_ready) begin
      got_pc.push_back(id_pc);
      got_instr.push_back(id_instr);
      got_cyc.push_back(ccount);
    end
    if (fired) req_log.push_back(a);
    @(posedge clk);
    #1;
    if (consumed && (mq.size() > 0)) void'(mq.pop_front());
    if (fired) mq.push_back(a);
    imem_rvalid = mem_en && (mq.size() > 0);
    imem_rdata  = (mq.size() > 0) ? (mq[0] ^ MKEY) : 32'h0;
    ccount++;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    req_log.delete(); got_pc.delete(); got_instr.delete(); got_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0; mem_en = 1'b0;
    mq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    ccount = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1; mem_en = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL first_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL first_addr: got %h want 00000000", imem_addr); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_id_valid: got %b want 0", id_valid); end
  endtask

  task automatic test_steady();
    do_reset();
    imem_ready = 1'b1; id_ready = 1'b1; mem_en = 1'b1;
    repeat (8) cyc();
    n_cmp++; if (got_pc.size() < 3) begin n_bad++; $display("FAIL steady_count: got %0d want >=3", got_pc.size()); end
    n_cmp++; if (got_pc[0] !== 32'h0) begin n_bad++; $display("FAIL steady_pc0: got %h want 00000000", got_pc[0]); end
    n_cmp++; if (got_pc[1] !== 32'h4) begin n_bad++; $display("FAIL steady_pc1: got %h want 00000004", got_pc[1]); end
    n_cmp++; if (got_pc[2] !== 32'h8) begin n_bad++; $display("FAIL steady_pc2: got %h want 00000008", got_pc[2]); end
    n_cmp++; if (got_instr[0] !== 32'h1357_9BDF) begin n_bad++; $display("FAIL steady_instr0: got %h want 13579bdf", got_instr[0]); end
    n_cmp++; if (got_cyc[0] != 2) begin n_bad++; $display("FAIL steady_latency: got cycle %0d want 2", got_cyc[0]); end
    n_cmp++; if (got_cyc[1] != 3) begin n_bad++; $display("FAIL steady_b2b: got cycle %0d want 3", got_cyc[1]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_ready = 1'b1; id_ready = 1'b0; mem_en = 1'b1;
    repeat (10) cyc();
    #1;
    n_cmp++; if (req_log.size() != 2) begin n_bad++; $display("FAIL bp_req_count: got %0d want 2", req_log.size()); end
    n_cmp++; if (req_log[1] !== 32'h4) begin n_bad++; $display("FAIL bp_req1: got %h want 00000004", req_log[1]); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_low: got %b want 0", imem_req); end
    n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL bp_id_valid: got %b want 1", id_valid); end
    n_cmp++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL bp_head_pc: got %h want 00000000", id_pc); end
    id_ready = 1'b1;
    repeat (6) cyc();
    n_cmp++; if (got_pc.size() < 2) begin n_bad++; $display("FAIL bp_deliv_count: got %0d want >=2", got_pc.size()); end
    n_cmp++; if (got_pc[0] !== 32'h0) begin n_bad++; $display("FAIL bp_deliv0: got %h want 00000000", got_pc[0]); end
    n_cmp++; if (got_pc[1] !== 32'h4) begin n_bad++; $display("FAIL bp_deliv1: got %h want 00000004", got_pc[1]); end
    n_cmp++; if (got_instr[1] !== 32'h1357_9BDB) begin n_bad++; $display("FAIL bp_instr1: got %h want 13579bdb", got_instr[1]); end
    n_cmp++; if (req_log[2] !== 32'h8) begin n_bad++; $display("FAIL bp_resume: got %h want 00000008", req_log[2]); end
  endtask

  task automatic test_redirect();
    do_reset();
    imem_ready = 1'b1; id_ready = 1'b1; mem_en = 1'b1;
    repeat (3) cyc();
    mem_en = 1'b0;
    repeat (2) cyc();
    #1;
    n_cmp++; if (req_log.size() != 4) begin n_bad++; $display("FAIL rd_setup_count: got %0d want 4", req_log.size()); end
    n_cmp++; if (req_log[3] !== 32'hC) begin n_bad++; $display("FAIL rd_setup_last: got %h want 0000000c", req_log[3]); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rd_setup_full: got %b want 0", imem_req); end
    clear_logs();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; mem_en = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rd_drop_credit: got %b want 0", imem_req); end
    cyc();
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rd_req_after: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL rd_addr: got %h want 00000100", imem_addr); end
    repeat (4) cyc();
    n_cmp++; if (got_pc.size() < 1) begin n_bad++; $display("FAIL rd_deliv_count: got %0d want >=1", got_pc.size()); end
    n_cmp++; if (got_pc[0] !== 32'h100) begin n_bad++; $display("FAIL rd_id_pc: got %h want 00000100", got_pc[0]); end
    n_cmp++; if (got_instr[0] !== 32'h1357_9ADF) begin n_bad++; $display("FAIL rd_id_instr: got %h want 13579adf", got_instr[0]); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    imem_ready = 1'b1; id_ready = 1'b0; mem_en = 1'b0;
    repeat (2) cyc();
    mem_en = 1'b1;
    cyc();
    clear_logs();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; id_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rr_no_req: got %b want 0", imem_req); end
    cyc();
    n_cmp++; if (req_log.size() != 0) begin n_bad++; $display("FAIL rr_none_issued: got %0d want 0", req_log.size()); end
    redirect_valid = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rr_credit: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h200) begin n_bad++; $display("FAIL rr_addr: got %h want 00000200", imem_addr); end
    repeat (4) cyc();
    n_cmp++; if (got_pc.size() < 1) begin n_bad++; $display("FAIL rr_deliv_count: got %0d want >=1", got_pc.size()); end
    n_cmp++; if (got_pc[0] !== 32'h200) begin n_bad++; $display("FAIL rr_id_pc: got %h want 00000200", got_pc[0]); end
    n_cmp++; if (got_instr[0] !== 32'h1357_99DF) begin n_bad++; $display("FAIL rr_id_instr: got %h want 135799df", got_instr[0]); end
  endtask

  task automatic test_ready_stall();
    do_reset();
    imem_ready = 1'b0; id_ready = 1'b1; mem_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL stall_req[%0d]: got %b want 1", i, imem_req); end
      n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL stall_addr[%0d]: got %h want 00000000", i, imem_addr); end
      cyc();
    end
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL stall_next_addr: got %h want 00000004", imem_addr); end
    repeat (2) cyc();
    n_cmp++; if (req_log.size() != 1) begin n_bad++; $display("FAIL stall_accepts: got %0d want 1", req_log.size()); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    imem_ready = 1'b1; id_ready = 1'b1; mem_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL wrap_redir_req: got %b want 0", imem_req); end
    cyc();
    redirect_valid = 1'b0;
    repeat (3) cyc();
    #1;
    n_cmp++; if (req_log.size() < 2) begin n_bad++; $display("FAIL wrap_req_count: got %0d want >=2", req_log.size()); end
    n_cmp++; if (req_log[0] !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_req0: got %h want fffffffc", req_log[0]); end
    n_cmp++; if (req_log[1] !== 32'h0) begin n_bad++; $display("FAIL wrap_req1: got %h want 00000000", req_log[1]); end
    n_cmp++; if (got_pc[0] !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_id_pc: got %h want fffffffc", got_pc[0]); end
    n_cmp++; if (got_instr[0] !== 32'hECA8_6423) begin n_bad++; $display("FAIL wrap_id_instr: got %h want eca86423", got_instr[0]); end
    n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_pre_rst_valid: got %b want 1", id_valid); end
    n_cmp++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL wrap_pre_rst_pc: got %h want 00000000", id_pc); end
    rst = 1'b1;
    #1;
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_id_valid: got %b want 0", id_valid); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL midrst_imem_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL midrst_addr: got %h want 00000000", imem_addr); end
    mq.delete();
    imem_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_backpressure();
    test_redirect();
    test_redirect_rvalid();
    test_ready_stall();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
